// File: rtl/gm_cuadratico_checker.sv
// Streaming golden-model checker: queues reference sample pairs and compares
// each DUT sample pair against the oldest queued reference, within a tolerance.
module gm_cuadratico_checker #(
  parameter int DEPTH         = 8,
  parameter int TOLERANCE     = 0,
  parameter bit STOP_ON_ERROR = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        ref_valid,
  input  logic [15:0] ref_dpi_1,
  input  logic [15:0] ref_dpi_2,
  input  logic        dut_valid,
  input  logic [15:0] dut_y_1,
  input  logic [15:0] dut_y_2,
  output logic        mismatch,
  output logic        err_sticky,
  output logic        overflow,
  output logic        underflow,
  output logic [31:0] sample_count,
  output logic [15:0] mismatch_count,
  output logic [16:0] max_abs_err,
  output logic [1:0]  state
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [16:0] TOL        = 17'(TOLERANCE);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  // Both strobes are valid-only: there is no ready/backpressure, so a strobe
  // seen with clk_enable=1 is consumed (or dropped/flagged) in that same cycle.
  logic        active, fifo_empty, fifo_full, push_req, pop_req;
  logic        bypass, do_pop, do_push, do_compare, drop, starve;
  logic [31:0] head;
  logic [15:0] cmp_1, cmp_2;
  logic [16:0] diff_1, diff_2, abs_1, abs_2, abs_big;
  logic        pair_fail;

  always_comb begin
    active     = clk_enable && (state_q != FAIL);
    fifo_empty = (count == '0);
    fifo_full  = (count == FULL_COUNT);
    push_req   = active && ref_valid;
    pop_req    = active && dut_valid && (state_q == RUN);
    bypass     = push_req && pop_req && fifo_empty;
    do_pop     = pop_req && !fifo_empty;
    do_compare = do_pop || bypass;
    starve     = pop_req && fifo_empty && !push_req;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push    = push_req && !bypass && (!fifo_full || do_pop);
    drop       = push_req && fifo_full && !do_pop;
    head       = mem[rd_ptr];
    cmp_1      = bypass ? ref_dpi_1 : head[31:16];
    cmp_2      = bypass ? ref_dpi_2 : head[15:0];
    diff_1     = {dut_y_1[15], dut_y_1} - {cmp_1[15], cmp_1};
    diff_2     = {dut_y_2[15], dut_y_2} - {cmp_2[15], cmp_2};
    abs_1      = diff_1[16] ? (~diff_1 + 17'd1) : diff_1;
    abs_2      = diff_2[16] ? (~diff_2 + 17'd1) : diff_2;
    abs_big    = (abs_1 > abs_2) ? abs_1 : abs_2;
    pair_fail  = (abs_1 > TOL) || (abs_2 > TOL);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clk_enable && ref_valid) state_d = RUN;
      RUN:     if (STOP_ON_ERROR && do_compare && pair_fail) state_d = FAIL;
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= {ref_dpi_1, ref_dpi_2};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      mismatch       <= 1'b0;
      err_sticky     <= 1'b0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
      sample_count   <= '0;
      mismatch_count <= '0;
      max_abs_err    <= '0;
    end else if (clk_enable) begin
      state_q  <= state_d;
      mismatch <= do_compare && pair_fail;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (drop)   overflow  <= 1'b1;
      if (starve) underflow <= 1'b1;
      if (drop || starve || (do_compare && pair_fail)) err_sticky <= 1'b1;
      if (do_compare) begin
        sample_count <= sample_count + 32'd1;
        if (pair_fail && (mismatch_count != 16'hFFFF))
          mismatch_count <= mismatch_count + 16'd1;
        if (abs_big > max_abs_err) max_abs_err <= abs_big;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_gm_cuadratico_checker.sv
// Bench for gm_cuadratico_checker: two instances (tolerant/free-running and
// strict/stop-on-error) driven by shared stimulus and checked against a model.
module tb_gm_cuadratico_checker;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, clk_enable, ref_valid, dut_valid;
  logic signed [15:0] ref_dpi_1, ref_dpi_2, dut_y_1, dut_y_2;

  logic        a_mismatch, a_err_sticky, a_overflow, a_underflow;
  logic [31:0] a_sample_count;
  logic [15:0] a_mismatch_count;
  logic [16:0] a_max_abs_err;
  logic [1:0]  a_state;
  logic        b_mismatch, b_err_sticky, b_overflow, b_underflow;
  logic [31:0] b_sample_count;
  logic [15:0] b_mismatch_count;
  logic [16:0] b_max_abs_err;
  logic [1:0]  b_state;

  gm_cuadratico_checker #(.DEPTH(DEPTH), .TOLERANCE(1), .STOP_ON_ERROR(1'b0)) u_a (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .ref_valid(ref_valid), .ref_dpi_1(ref_dpi_1), .ref_dpi_2(ref_dpi_2),
    .dut_valid(dut_valid), .dut_y_1(dut_y_1), .dut_y_2(dut_y_2),
    .mismatch(a_mismatch), .err_sticky(a_err_sticky), .overflow(a_overflow),
    .underflow(a_underflow), .sample_count(a_sample_count),
    .mismatch_count(a_mismatch_count), .max_abs_err(a_max_abs_err), .state(a_state)
  );

  gm_cuadratico_checker #(.DEPTH(DEPTH), .TOLERANCE(0), .STOP_ON_ERROR(1'b1)) u_b (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .ref_valid(ref_valid), .ref_dpi_1(ref_dpi_1), .ref_dpi_2(ref_dpi_2),
    .dut_valid(dut_valid), .dut_y_1(dut_y_1), .dut_y_2(dut_y_2),
    .mismatch(b_mismatch), .err_sticky(b_err_sticky), .overflow(b_overflow),
    .underflow(b_underflow), .sample_count(b_sample_count),
    .mismatch_count(b_mismatch_count), .max_abs_err(b_max_abs_err), .state(b_state)
  );

  // ---------------- reference model (per instance k) ----------------
  int          mf1 [2][DEPTH];
  int          mf2 [2][DEPTH];
  int          m_head [2];
  int          m_cnt [2];
  int          m_state [2];   // 0 idle, 1 running, 2 frozen
  bit          m_mis [2];
  bit          m_err [2];
  bit          m_ovf [2];
  bit          m_udf [2];
  logic [31:0] m_samples [2];
  int          m_mcount [2];
  int          m_max [2];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_step(input int k, input int tol, input bit stop);
    int r1, r2, e1, e2;
    bit have, consumed;
    if (reset) begin
      m_head[k] = 0; m_cnt[k] = 0; m_state[k] = 0;
      m_mis[k] = 0; m_err[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
      m_samples[k] = '0; m_mcount[k] = 0; m_max[k] = 0;
      return;
    end
    if (!clk_enable) return;
    m_mis[k] = 0;
    if (m_state[k] == 2) return;
    have = 0; consumed = 0; r1 = 0; r2 = 0;
    if (dut_valid && m_state[k] == 1) begin
      if (m_cnt[k] > 0) begin
        r1 = mf1[k][m_head[k]];
        r2 = mf2[k][m_head[k]];
        m_head[k] = (m_head[k] + 1) % DEPTH;
        m_cnt[k]--;
        have = 1;
      end else if (ref_valid) begin
        r1 = int'(ref_dpi_1); r2 = int'(ref_dpi_2);
        have = 1; consumed = 1;
      end else begin
        m_udf[k] = 1; m_err[k] = 1;
      end
    end
    if (ref_valid && !consumed) begin
      if (m_cnt[k] < DEPTH) begin
        mf1[k][(m_head[k] + m_cnt[k]) % DEPTH] = int'(ref_dpi_1);
        mf2[k][(m_head[k] + m_cnt[k]) % DEPTH] = int'(ref_dpi_2);
        m_cnt[k]++;
      end else begin
        m_ovf[k] = 1; m_err[k] = 1;
      end
    end
    if (ref_valid && m_state[k] == 0) m_state[k] = 1;
    if (have) begin
      e1 = iabs(int'(dut_y_1) - r1);
      e2 = iabs(int'(dut_y_2) - r2);
      m_samples[k] = m_samples[k] + 32'd1;
      if (e1 > m_max[k]) m_max[k] = e1;
      if (e2 > m_max[k]) m_max[k] = e2;
      if (e1 > tol || e2 > tol) begin
        m_mis[k] = 1; m_err[k] = 1;
        if (m_mcount[k] < 65535) m_mcount[k]++;
        if (stop) m_state[k] = 2;
      end
    end
  endtask

  // ---------------- scoreboard / checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit a_seen;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input string p, input int k,
                           input logic mis, input logic err, input logic ovf, input logic udf,
                           input logic [31:0] sc, input logic [15:0] mc,
                           input logic [16:0] mx, input logic [1:0] st);
    check_eq({p, "_mismatch"},       64'(mis), 64'(m_mis[k]));
    check_eq({p, "_err_sticky"},     64'(err), 64'(m_err[k]));
    check_eq({p, "_overflow"},       64'(ovf), 64'(m_ovf[k]));
    check_eq({p, "_underflow"},      64'(udf), 64'(m_udf[k]));
    check_eq({p, "_sample_count"},   64'(sc),  64'(m_samples[k]));
    check_eq({p, "_mismatch_count"}, 64'(mc),  64'(m_mcount[k]));
    check_eq({p, "_max_abs_err"},    64'(mx),  64'(m_max[k]));
    check_eq({p, "_state"},          64'(st),  64'(m_state[k]));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit r, input bit en, input bit rv, input int x1, input int x2,
                       input bit dv, input int y1, input int y2);
    reset = r; clk_enable = en;
    ref_valid = rv; ref_dpi_1 = 16'(x1); ref_dpi_2 = 16'(x2);
    dut_valid = dv; dut_y_1 = 16'(y1); dut_y_2 = 16'(y2);
    @(posedge clk);
    model_step(0, 1, 1'b0);
    model_step(1, 0, 1'b1);
    #1;
    a_seen |= a_mismatch;
    check_dut("a", 0, a_mismatch, a_err_sticky, a_overflow, a_underflow,
              a_sample_count, a_mismatch_count, a_max_abs_err, a_state);
    check_dut("b", 1, b_mismatch, b_err_sticky, b_overflow, b_underflow,
              b_sample_count, b_mismatch_count, b_max_abs_err, b_state);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input int x1, input int x2);
    cycle(0, 1, 1, x1, x2, 0, 0, 0);
  endtask

  task automatic pop(input int y1, input int y2);
    cycle(0, 1, 0, 0, 0, 1, y1, y2);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  int vals [3] = '{100, -200, 300};

  initial begin
    reset = 1'b1; clk_enable = 1'b0; ref_valid = 1'b0; dut_valid = 1'b0;
    ref_dpi_1 = '0; ref_dpi_2 = '0; dut_y_1 = '0; dut_y_2 = '0;
    a_seen = 1'b0;

    // Reset state (reset applied with clk_enable low)
    do_reset();
    check_eq("rst_state", 64'(a_state), 64'd0);
    check_eq("rst_samples", 64'(a_sample_count), 64'd0);
    check_eq("rst_err", 64'(a_err_sticky), 64'd0);

    // Matched stream, DUT lags by two samples, one sample per 5 clocks
    a_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, i < 3, (i < 3) ? vals[i] : 0, 0, i >= 2, (i >= 2) ? vals[i-2] : 0, 0);
      idle(4);
    end
    check_eq("match_samples", 64'(a_sample_count), 64'd3);
    check_eq("match_no_pulse", 64'(a_seen), 64'd0);
    check_eq("match_max", 64'(a_max_abs_err), 64'd0);

    // Tolerance 1 on instance a
    do_reset();
    push(1000, 0);
    pop(1001, 0);
    check_eq("tol_pass", 64'(a_mismatch), 64'd0);
    push(1000, 0);
    pop(1002, 0);
    check_eq("tol_pulse", 64'(a_mismatch), 64'd1);
    check_eq("tol_mcount", 64'(a_mismatch_count), 64'd1);
    check_eq("tol_max", 64'(a_max_abs_err), 64'd2);
    idle(1);
    check_eq("tol_pulse_end", 64'(a_mismatch), 64'd0);

    // Extremes
    do_reset();
    push(-32768, 32767);
    pop(32767, -32768);
    check_eq("ext_max", 64'(a_max_abs_err), 64'd65535);
    check_eq("ext_err", 64'(a_err_sticky), 64'd1);

    // FIFO edges: overflow, drain with underflow, bypass on empty
    do_reset();
    for (int i = 0; i < 9; i++) push(i * 100 - 400, i);
    check_eq("fifo_ovf", 64'(a_overflow), 64'd1);
    check_eq("fifo_no_udf", 64'(a_underflow), 64'd0);
    for (int i = 0; i < 9; i++) pop(i * 100 - 400, i);
    check_eq("fifo_drain_samples", 64'(a_sample_count), 64'd8);
    check_eq("fifo_udf", 64'(a_underflow), 64'd1);
    check_eq("fifo_drain_mcount", 64'(a_mismatch_count), 64'd0);
    do_reset();
    push(5, 5);
    pop(5, 5);
    cycle(0, 1, 1, 77, -77, 1, 77, -77);
    check_eq("bypass_samples", 64'(a_sample_count), 64'd2);
    check_eq("bypass_no_udf", 64'(a_underflow), 64'd0);
    check_eq("bypass_no_mis", 64'(a_mismatch), 64'd0);

    // Stop-on-error on instance b
    do_reset();
    push(10, 0); push(20, 0); push(30, 0);
    pop(10, 0);
    pop(21, 0);
    check_eq("stop_state", 64'(b_state), 64'd2);
    check_eq("stop_pulse", 64'(b_mismatch), 64'd1);
    cycle(0, 1, 1, 40, 0, 1, 30, 0);
    check_eq("stop_frozen_samples", 64'(b_sample_count), 64'd2);
    check_eq("stop_pulse_end", 64'(b_mismatch), 64'd0);
    do_reset();
    check_eq("stop_rst_state", 64'(b_state), 64'd0);
    check_eq("stop_rst_samples", 64'(b_sample_count), 64'd0);
    check_eq("stop_rst_mcount", 64'(b_mismatch_count), 64'd0);

    // clk_enable low, held pulse, reset with queued samples
    do_reset();
    push(5, 0);
    cycle(0, 0, 0, 0, 0, 1, 9, 0);
    check_eq("en_low_no_cmp", 64'(a_sample_count), 64'd0);
    pop(50, 0);
    check_eq("en_pulse", 64'(a_mismatch), 64'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("en_pulse_hold", 64'(a_mismatch), 64'd1);
    idle(1);
    check_eq("en_pulse_release", 64'(a_mismatch), 64'd0);
    do_reset();
    push(1, 0); push(2, 0); push(3, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    pop(1, 0);
    check_eq("rq_idle_state", 64'(a_state), 64'd0);
    check_eq("rq_no_udf", 64'(a_underflow), 64'd0);
    push(4, 0);
    pop(4, 0);
    check_eq("rq_empty_samples", 64'(a_sample_count), 64'd1);
    check_eq("rq_empty_mcount", 64'(a_mismatch_count), 64'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int x1, x2, y1, y2;
      x1 = int'($urandom_range(0, 6)) - 3;
      x2 = int'($urandom_range(0, 6)) - 3;
      y1 = int'($urandom_range(0, 6)) - 3;
      y2 = int'($urandom_range(0, 6)) - 3;
      if ($urandom_range(0, 19) == 0) y1 = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 19) == 0) x2 = int'($urandom_range(0, 65535)) - 32768;
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) < 4, x1, x2,
            $urandom_range(0, 9) < 4, y1, y2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gm_cuadratico_checker.md
GM_CUADRATICO_CHECKER -- requirements
Module: gm_cuadratico_checker

Interface
REQ-001 Parameters SHALL be:
- DEPTH, 8: reference FIFO depth in samples; a power of two, 2..64.
- TOLERANCE, 0: maximum allowed |dut - ref| per channel, in LSB.
- STOP_ON_ERROR, 0: when 1, the first mismatch freezes the checker.
REQ-002 Ports SHALL be, clock and reset first:
- clk, in, 1: the single clock.
- reset, in, 1: synchronous, active-high reset.
- clk_enable, in, 1: when low, all state holds and all inputs are ignored.
- ref_valid, in, 1: one-cycle strobe that pushes one reference sample pair.
- ref_dpi_1, ref_dpi_2, in, 16 each: signed reference channels 1 and 2.
- dut_valid, in, 1: one-cycle strobe marking one DUT output sample pair.
- dut_y_1, dut_y_2, in, 16 each: signed DUT channels 1 and 2.
- mismatch, out, 1: one-cycle pulse when a compared pair fails.
- err_sticky, out, 1: set on any mismatch, overflow or underflow.
- overflow, out, 1: sticky; a reference sample was dropped because the FIFO was full.
- underflow, out, 1: sticky; a DUT sample arrived with no reference available.
- sample_count, out, 32: number of compared pairs.
- mismatch_count, out, 16: number of failing pairs; saturates at 0xFFFF.
- max_abs_err, out, 17: largest |dut - ref| seen on either channel.
- state, out, 2: FSM state, encoded IDLE=0, RUN=1, FAIL=2.

Function
REQ-003 A ref_valid cycle with clk_enable=1 SHALL push {ref_dpi_1, ref_dpi_2} into a FIFO of DEPTH entries.
REQ-004 A dut_valid cycle with clk_enable=1 in RUN SHALL pop the oldest reference pair and compare it with {dut_y_1, dut_y_2}.
REQ-005 Comparison arithmetic SHALL be:
- per channel, diff = sign-extended 17-bit (dut - ref);
- a channel passes when |diff| <= TOLERANCE;
- the pair passes only if both channels pass.
REQ-006 Results of a comparison SHALL become visible exactly one clock after the dut_valid cycle; this applies to mismatch, the counters and max_abs_err.
REQ-007 sample_count SHALL increment on every comparison, and wrap at 2^32.
REQ-008 mismatch_count SHALL increment on each failing pair, and saturate at 0xFFFF.
REQ-009 max_abs_err SHALL update to the larger of its current value and both channel |diff| values; |-32768 - 32767| = 65535 SHALL be representable.
REQ-010 Push with pop on an empty FIFO: the checker SHALL bypass the FIFO and compare the DUT pair against the incoming reference pair; this is not an underflow.
REQ-011 Push with pop on a full FIFO: the checker SHALL perform both operations, and the occupancy SHALL stay DEPTH.
REQ-012 Push on a full FIFO without pop: the checker SHALL drop the sample and set overflow and err_sticky.
REQ-013 Pop on an empty FIFO without push: the checker SHALL set underflow and err_sticky; no comparison occurs and sample_count holds.
REQ-014 FSM transitions SHALL be:
- IDLE -> RUN on the first accepted ref_valid;
- dut_valid in IDLE is ignored and is not an underflow;
- RUN -> FAIL on a mismatch only when STOP_ON_ERROR=1;
- otherwise the FSM stays in RUN;
- FAIL is left only by reset.
REQ-015 In FAIL the checker SHALL ignore pushes and pops and freeze all counters; mismatch stays low after its single pulse.
REQ-016 While clk_enable=0, strobes SHALL be ignored, all state SHALL hold, and a pending mismatch pulse SHALL hold until the next enabled cycle.

Reset
REQ-017 When reset=1 at a rising clk edge, the following SHALL be cleared regardless of clk_enable:
- FIFO emptied;
- state=IDLE;
- mismatch, err_sticky, overflow and underflow = 0;
- sample_count, mismatch_count and max_abs_err = 0.
REQ-018 A reset asserted mid-operation SHALL discard all queued samples and any result still in flight; no mismatch pulse follows it.

Verification
REQ-019 Directed scenarios the bench SHALL cover:
- Matched stream: ref pushes 100, -200, 300 on channel 1 then DUT returns the same values 2 samples later at 1 sample per 5 clks -> sample_count=3, mismatch never pulses, max_abs_err=0.
- Tolerance: TOLERANCE=1, ref 1000, dut 1001 -> pass; ref 1000, dut 1002 -> mismatch pulse one cycle after dut_valid, mismatch_count=1, max_abs_err=2.
- Extremes: ref -32768, dut 32767 -> max_abs_err=65535, err_sticky=1.
- FIFO edges: push 9 samples with DEPTH=8 and no pop -> overflow=1. Then pop 9 -> 8 comparisons and underflow=1. Simultaneous push and pop on an empty FIFO with equal values -> pass, no underflow.
- STOP_ON_ERROR=1: mismatch on the 2nd sample -> state=FAIL; later strobes leave sample_count=2. Reset -> state=IDLE, all counters 0.
- clk_enable low during a dut_valid strobe -> no comparison. Reset pulsed with 3 samples queued -> the FIFO is empty, and the next dut_valid in IDLE is ignored.
